// File: rtl/tst_strobe_sched_if.sv
// Strobe-scheduler bus: frame trigger and timing config in, strobes and status out.
interface tst_strobe_sched_if #(
  parameter int unsigned CW = 16,
  parameter int unsigned NW = 8
);
  logic          en;
  logic          TNO;
  logic [2:0]    mode_req;
  logic [CW-1:0] t_ni;
  logic [CW-1:0] len_i;
  logic [CW-1:0] t_np;
  logic [CW-1:0] len_p;
  logic [CW-1:0] period;
  logic [NW-1:0] n_cyc;

  logic          TNC;
  logic          TNI;
  logic          TKI;
  logic          TNP;
  logic          TKP;
  logic [2:0]    upr;
  logic          busy;
  logic [NW-1:0] cyc_cnt;
  logic          done;
  logic          err_cfg;
  logic          overrun;

  modport master (
    output en, TNO, mode_req, t_ni, len_i, t_np, len_p, period, n_cyc,
    input  TNC, TNI, TKI, TNP, TKP, upr, busy, cyc_cnt, done, err_cfg, overrun
  );

  modport slave (
    input  en, TNO, mode_req, t_ni, len_i, t_np, len_p, period, n_cyc,
    output TNC, TNI, TKI, TNP, TKP, upr, busy, cyc_cnt, done, err_cfg, overrun
  );
endinterface

// File: rtl/tst_strobe_sched.sv
// Frame timing-strobe scheduler: on an accepted TNO runs n_cyc periods, each issuing
// TNC/TNI/TKI/TNP/TKP strobes, and freezes the test-mux mode for the whole frame.
module tst_strobe_sched #(
  parameter int unsigned CW = 16,
  parameter int unsigned NW = 8
) (
  input  logic             clk,
  input  logic             rst,
  tst_strobe_sched_if.slave bus
);
  localparam int unsigned XW = CW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [CW-1:0] t_ni;
    logic [CW-1:0] len_i;
    logic [CW-1:0] t_np;
    logic [CW-1:0] len_p;
    logic [CW-1:0] period;
    logic [NW-1:0] n_cyc;
  } cfg_t;

  state_t        state, state_nxt;
  cfg_t          cfg, cfg_nxt, cfg_in_c;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [NW-1:0] cyc, cyc_nxt;
  logic [4:0]    strb, strb_nxt;      // {TKP, TNP, TKI, TNI, TNC}
  logic [2:0]    upr, upr_nxt;
  logic          busy, busy_nxt;
  logic          done, done_nxt;
  logic          err, err_nxt;
  logic          ovr, ovr_nxt;

  logic [XW-1:0] ni_end_c;
  logic [XW-1:0] np_end_c;
  logic          valid_c;
  logic          run_nxt_c;
  logic [CW-1:0] tki_at_c;
  logic [CW-1:0] tkp_at_c;

  // Config check is done one bit wider so oversized offsets cannot wrap into range
  always_comb begin
    cfg_in_c.t_ni   = bus.t_ni;
    cfg_in_c.len_i  = bus.len_i;
    cfg_in_c.t_np   = bus.t_np;
    cfg_in_c.len_p  = bus.len_p;
    cfg_in_c.period = bus.period;
    cfg_in_c.n_cyc  = bus.n_cyc;
    ni_end_c = XW'(bus.t_ni) + XW'(bus.len_i);
    np_end_c = XW'(bus.t_np) + XW'(bus.len_p);
    valid_c  = (bus.t_ni != '0) && (bus.len_i != '0) && (bus.len_p != '0) &&
               (bus.n_cyc != '0) && (ni_end_c <= XW'(bus.t_np)) &&
               ((np_end_c + XW'(1)) <= XW'(bus.period));
  end

  // Next-state, counters and strobe decode from the post-edge counter value
  always_comb begin
    state_nxt = state;
    cfg_nxt   = cfg;
    cnt_nxt   = cnt;
    cyc_nxt   = cyc;
    upr_nxt   = upr;
    ovr_nxt   = ovr;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    strb_nxt  = '0;
    busy_nxt  = 1'b0;
    run_nxt_c = 1'b0;
    tki_at_c  = '0;
    tkp_at_c  = '0;

    case (state)
      IDLE: begin
        if (bus.TNO && bus.en) begin
          if (valid_c) begin
            cfg_nxt   = cfg_in_c;
            upr_nxt   = bus.mode_req;
            cnt_nxt   = '0;
            cyc_nxt   = '0;
            ovr_nxt   = 1'b0;
            state_nxt = RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.TNO) ovr_nxt = 1'b1;
        if (cnt == cfg.period - CW'(1)) begin
          cnt_nxt = '0;
          if ((cyc == cfg.n_cyc - NW'(1)) || !bus.en) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            cyc_nxt = cyc + NW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Sums cannot wrap: an accepted config bounds them below period
    run_nxt_c = (state_nxt == RUN);
    tki_at_c  = cfg_nxt.t_ni + cfg_nxt.len_i;
    tkp_at_c  = cfg_nxt.t_np + cfg_nxt.len_p;
    busy_nxt  = run_nxt_c;
    strb_nxt[0] = run_nxt_c && (cnt_nxt == '0);
    strb_nxt[1] = run_nxt_c && (cnt_nxt == cfg_nxt.t_ni);
    strb_nxt[2] = run_nxt_c && (cnt_nxt == tki_at_c);
    strb_nxt[3] = run_nxt_c && (cnt_nxt == cfg_nxt.t_np);
    strb_nxt[4] = run_nxt_c && (cnt_nxt == tkp_at_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cfg   <= '0;
      cnt   <= '0;
      cyc   <= '0;
      strb  <= '0;
      upr   <= 3'b000;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      state <= state_nxt;
      cfg   <= cfg_nxt;
      cnt   <= cnt_nxt;
      cyc   <= cyc_nxt;
      strb  <= strb_nxt;
      upr   <= upr_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      ovr   <= ovr_nxt;
    end
  end

  assign bus.TNC     = strb[0];
  assign bus.TNI     = strb[1];
  assign bus.TKI     = strb[2];
  assign bus.TNP     = strb[3];
  assign bus.TKP     = strb[4];
  assign bus.upr     = upr;
  assign bus.busy    = busy;
  assign bus.cyc_cnt = cyc;
  assign bus.done    = done;
  assign bus.err_cfg = err;
  assign bus.overrun = ovr;
endmodule
